// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I pipeline front end.
//   - RESET_PC_DEF / NOP_INST_DEF : default first fetch address and bubble word
//   - fetch_state_e               : instruction-fetch control states
//   - if_id_t                     : IF/ID pipeline bundle, also used by decode
//   - if_id_bubble()              : builds the canonical bubble bundle
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0004;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // ADDI x0,x0,0

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [31:0] nop_inst);
        if_id_t b;
        b.valid = 1'b0;
        b.pc    = 32'h0;
        b.pc4   = 32'h0;
        b.inst  = nop_inst;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with bubble, load and hold controls.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (resets to bubble)
//     bubble_i    : load the bubble bundle (highest priority)
//     load_i      : load d_i
//     d_i         : incoming fetch bundle
//     q_o         : registered IF/ID bundle
//   With neither control asserted the register holds.
// ----------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bubble_i,
    input  logic   load_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= if_id_bubble(NOP_INST);
        end else if (bubble_i) begin
            q_q <= if_id_bubble(NOP_INST);
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, drives
//   the combinational instruction-memory address and fills IF/ID.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     stall               : hazard unit hold of PC and IF/ID
//     redirect_valid/_pc  : EX-stage taken control transfer and its target
//     imem_addr/imem_inst : instruction memory address (= PC) / returned word
//     if_id_*             : IF/ID register contents
//     fetch_err/_pc       : sticky misaligned-redirect trap and its target
//     fetch_cnt           : instructions loaded valid into IF/ID (wraps)
// ----------------------------------------------------------------------------
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    output logic             if_id_valid,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_inst,
    output logic             fetch_err,
    output logic [31:0]      fetch_err_pc,
    output logic [CNT_W-1:0] fetch_cnt
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             err_q;
    logic [31:0]      err_pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             redir_bad;
    logic             load, bubble, err_set, cnt_inc;
    logic [31:0]      pc_plus4;
    if_id_t           if_id_d, if_id_q;

    // Only aligned targets are ever loaded, so pc stays word aligned.
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign pc_plus4  = pc_q + 32'd4;  // modulo 2^32

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redir_bad) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Output / datapath control
    always_comb begin
        load    = 1'b0;
        bubble  = 1'b0;
        err_set = 1'b0;
        cnt_inc = 1'b0;
        pc_d    = pc_q;
        case (state_q)
            S_RUN: begin
                if (redir_bad) begin
                    err_set = 1'b1;
                    bubble  = 1'b1;
                end else if (redirect_valid) begin
                    // Redirect flushes the wrong-path fetch and beats stall.
                    pc_d   = redirect_pc;
                    bubble = 1'b1;
                end else if (!stall) begin
                    load    = 1'b1;
                    cnt_inc = 1'b1;
                    pc_d    = pc_plus4;
                end
            end
            default: bubble = 1'b1;  // S_BOOT, S_HALT
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            err_q    <= 1'b0;
            err_pc_q <= 32'h0;
            cnt_q    <= '0;
        end else begin
            pc_q <= pc_d;
            if (err_set) begin
                err_q    <= 1'b1;
                err_pc_q <= redirect_pc;
            end
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        if_id_d.valid = 1'b1;
        if_id_d.pc    = pc_q;
        if_id_d.pc4   = pc_plus4;
        if_id_d.inst  = imem_inst;
    end

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (bubble),
        .load_i   (load),
        .d_i      (if_id_d),
        .q_o      (if_id_q)
    );

    assign imem_addr    = pc_q;
    assign if_id_valid  = if_id_q.valid;
    assign if_id_pc     = if_id_q.pc;
    assign if_id_pc4    = if_id_q.pc4;
    assign if_id_inst   = if_id_q.inst;
    assign fetch_err    = err_q;
    assign fetch_err_pc = err_pc_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit with a small combinational imem model.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LUI_W    = 32'h0000_10B7;
    localparam logic [31:0] ANDI_W   = 32'h0FF0_F093;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        fetch_err;
    logic [31:0] fetch_err_pc;
    logic [31:0] fetch_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_inst     (if_id_inst),
        .fetch_err      (fetch_err),
        .fetch_err_pc   (fetch_err_pc),
        .fetch_cnt      (fetch_cnt)
    );

    // Memory model: two known words, everything else tagged by address.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        if (a == 32'h04)      return LUI_W;
        else if (a == 32'h08) return ANDI_W;
        else                  return 32'hA500_0000 ^ a;
    endfunction

    assign imem_inst = imem_f(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        check({tag, "_inst"},  if_id_inst, NOP);
        check({tag, "_pc"},    if_id_pc, 32'h0);
        check({tag, "_pc4"},   if_id_pc4, 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check_bubble(tag);
        check({tag, "_addr"},   imem_addr, 32'h4);
        check({tag, "_err"},    {31'h0, fetch_err}, 32'h0);
        check({tag, "_errpc"},  fetch_err_pc, 32'h0);
        check({tag, "_cnt"},    fetch_cnt, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #12;
        check_reset("rst");
        rst_n = 1'b1;

        // Boot cycle: bubble, PC held at RESET_PC.
        step();
        check_bubble("boot");
        check("boot_addr", imem_addr, 32'h4);
        check("boot_cnt", fetch_cnt, 32'h0);

        step();
        check("f1_pc", if_id_pc, 32'h4);
        check("f1_inst", if_id_inst, LUI_W);
        check("f1_valid", {31'h0, if_id_valid}, 32'h1);
        check("f1_cnt", fetch_cnt, 32'h1);
        check("f1_addr", imem_addr, 32'h8);

        step();
        check("f2_pc", if_id_pc, 32'h8);
        check("f2_pc4", if_id_pc4, 32'hC);
        check("f2_inst", if_id_inst, ANDI_W);
        check("f2_cnt", fetch_cnt, 32'h2);

        step();
        check("f3_pc", if_id_pc, 32'hC);
        check("f3_addr", imem_addr, 32'h10);

        // Stall three cycles at pc=0x10.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h10);
            check("stall_pc", if_id_pc, 32'hC);
            check("stall_cnt", fetch_cnt, 32'h3);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", if_id_pc, 32'h10);
        check("unstall_inst", if_id_inst, 32'hA500_0010);
        check("unstall_cnt", fetch_cnt, 32'h4);

        // Advance 0x14 -> 0x30.
        repeat (7) step();
        check("adv_addr", imem_addr, 32'h30);
        check("adv_pc", if_id_pc, 32'h2C);
        check("adv_cnt", fetch_cnt, 32'd11);

        // Aligned redirect.
        redirect_valid = 1'b1;
        redirect_pc = 32'h12C;
        step();
        redirect_valid = 1'b0;
        check_bubble("redir");
        check("redir_addr", imem_addr, 32'h12C);
        check("redir_cnt", fetch_cnt, 32'd11);
        step();
        check("redir_pc", if_id_pc, 32'h12C);
        check("redir_inst", if_id_inst, 32'hA500_012C);
        check("redir_cnt2", fetch_cnt, 32'd12);

        // Redirect beats stall.
        redirect_valid = 1'b1;
        redirect_pc = 32'h1F8;
        stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check_bubble("rs");
        check("rs_addr", imem_addr, 32'h1F8);
        step();
        check("rs_pc", if_id_pc, 32'h1F8);
        check("rs_cnt", fetch_cnt, 32'd13);

        // PC wrap at top of address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_addr1", imem_addr, 32'h0);
        step();
        check("wrap_pc2", if_id_pc, 32'h0);
        check("wrap_pc4b", if_id_pc4, 32'h4);
        check("wrap_cnt", fetch_cnt, 32'd15);

        // Misaligned redirect -> trap and halt.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0052;
        step();
        check("mis_err", {31'h0, fetch_err}, 32'h1);
        check("mis_errpc", fetch_err_pc, 32'h52);
        check_bubble("mis");
        check("mis_addr", imem_addr, 32'h4);
        for (int i = 0; i < 12; i++) begin
            redirect_valid = (i % 3) != 2;
            redirect_pc = (i % 2 == 0) ? 32'h200 : 32'h61;
            stall = (i % 4) == 1;
            step();
            check("halt_valid", {31'h0, if_id_valid}, 32'h0);
            check("halt_inst", if_id_inst, NOP);
            check("halt_addr", imem_addr, 32'h4);
            check("halt_cnt", fetch_cnt, 32'd15);
            check("halt_errpc", fetch_err_pc, 32'h52);
        end
        redirect_valid = 1'b0;
        stall = 1'b0;

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        #1;
        rst_n = 1'b1;
        step();
        check_bubble("reboot");
        step();
        check("post_pc", if_id_pc, 32'h4);
        check("post_inst", if_id_inst, LUI_W);
        check("post_cnt", fetch_cnt, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
